// File: rtl/pkt_fifo_pkg.sv
// Shared types and Gray helpers for the store-and-forward packet FIFO.
package pkt_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer.
module gray_ptr_sync #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_gray,
  output logic [W-1:0] q_gray
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= '0;
      q_gray <= '0;
    end else begin
      meta   <= d_gray;
      q_gray <= meta;
    end
  end

endmodule

// File: rtl/pkt_async_fifo_sf.sv
// Store-and-forward async packet FIFO: one RAM, commit pointer, rollback.
module pkt_async_fifo_sf
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int ALF_THRESH = 768,
  parameter int CNT_W      = 16
) (
  input  logic              wrclk,
  input  logic              wr_reset,
  input  logic              rdclk,
  input  logic              rd_reset,
  input  logic [DATA_W-1:0] rx_tdata,
  input  logic              rx_tvalid,
  input  logic              rx_tlast,
  input  logic              rx_tuser,
  output logic              rx_alf,
  output logic [DATA_W-1:0] tx_tdata,
  output logic              tx_tvalid,
  output logic              tx_tlast,
  output logic              tx_tuser,
  input  logic              tx_tready,
  output logic [CNT_W-1:0]  pkt_in_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  pkt_out_cnt
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_W);
  localparam logic [PW-1:0] ALF = PW'(ALF_THRESH);

  logic [DATA_W:0] mem [1 << ADDR_W];

  wr_state_e state, state_n;
  logic [PW-1:0] wr_ptr, wr_ptr_n;
  logic [PW-1:0] commit_ptr, commit_n;
  logic [PW-1:0] commit_gray, commit_gray_s;
  logic [PW-1:0] rd_ptr_sync, rd_gray_s;
  logic          drop_late, late_n;
  logic          we, in_inc, drop_inc, full;

  assign rd_ptr_sync = PW'(gray2bin(32'(rd_gray_s)));
  assign full = (wr_ptr - rd_ptr_sync) == DEPTH;

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    commit_n = commit_ptr;
    late_n   = drop_late;
    we       = 1'b0;
    in_inc   = 1'b0;
    drop_inc = 1'b0;
    unique case (state)
      IDLE: if (rx_tvalid) begin
        if (rx_alf) begin
          late_n   = !rx_tlast;
          drop_inc = rx_tlast;
          state_n  = rx_tlast ? IDLE : DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          state_n  = RECV;
        end
      end
      RECV: if (rx_tvalid) begin
        if (full) begin
          wr_ptr_n = commit_ptr;
          drop_inc = 1'b1;
          late_n   = 1'b0;
          state_n  = rx_tlast ? IDLE : DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
        end
      end
      DROP: if (rx_tvalid && rx_tlast) begin
        drop_inc = drop_late;
        late_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // accepted last beat: commit or roll back the whole packet
    if (we && rx_tlast) begin
      state_n = IDLE;
      if (rx_tuser) begin
        wr_ptr_n = commit_ptr;
        drop_inc = 1'b1;
      end else begin
        commit_n = wr_ptr + 1'b1;
        in_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge wrclk or negedge wr_reset) begin
    if (!wr_reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      commit_gray <= '0;
      drop_late   <= 1'b0;
      rx_alf      <= 1'b0;
      pkt_in_cnt  <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      wr_ptr      <= wr_ptr_n;
      commit_ptr  <= commit_n;
      commit_gray <= PW'(bin2gray(32'(commit_n)));
      drop_late   <= late_n;
      rx_alf      <= (wr_ptr_n - rd_ptr_sync) >= ALF;
      if (in_inc)
        pkt_in_cnt <= pkt_in_cnt + 1'b1;
      if (drop_inc)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge wrclk) begin
    if (we)
      mem[wr_ptr[ADDR_W-1:0]] <= {rx_tlast, rx_tdata};
  end

  logic [PW-1:0] rd_addr, rd_ptr, rd_ptr_n, rd_gray, commit_sync;
  logic          avail, load, pop;

  gray_ptr_sync #(.W(PW)) u_commit_sync (
    .clk    (rdclk),
    .rst_n  (rd_reset),
    .d_gray (commit_gray),
    .q_gray (commit_gray_s)
  );

  gray_ptr_sync #(.W(PW)) u_rd_sync (
    .clk    (wrclk),
    .rst_n  (wr_reset),
    .d_gray (rd_gray),
    .q_gray (rd_gray_s)
  );

  assign commit_sync = PW'(gray2bin(32'(commit_gray_s)));
  assign avail       = rd_addr != commit_sync;
  assign pop         = tx_tvalid && tx_tready;
  assign load        = avail && (!tx_tvalid || tx_tready);
  // freed space only counts words the sink has actually taken
  assign rd_ptr_n    = rd_ptr + PW'(pop);
  assign tx_tuser    = 1'b0;

  always_ff @(posedge rdclk or negedge rd_reset) begin
    if (!rd_reset) begin
      rd_addr     <= '0;
      rd_ptr      <= '0;
      rd_gray     <= '0;
      tx_tvalid   <= 1'b0;
      tx_tdata    <= '0;
      tx_tlast    <= 1'b0;
      pkt_out_cnt <= '0;
    end else begin
      rd_ptr  <= rd_ptr_n;
      rd_gray <= PW'(bin2gray(32'(rd_ptr_n)));
      if (load) begin
        {tx_tlast, tx_tdata} <= mem[rd_addr[ADDR_W-1:0]];
        rd_addr   <= rd_addr + 1'b1;
        tx_tvalid <= 1'b1;
      end else if (pop) begin
        tx_tvalid <= 1'b0;
      end
      if (pop && tx_tlast)
        pkt_out_cnt <= pkt_out_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_async_fifo_sf.sv
// Bench for pkt_async_fifo_sf: packet-level model plus per-beat compare.
module tb_pkt_async_fifo_sf;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int ALF   = 768;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          wrclk = 0;
  logic          rdclk = 0;
  logic          wr_reset = 0;
  logic          rd_reset = 0;
  logic [DW-1:0] rx_tdata = '0;
  logic          rx_tvalid = 0;
  logic          rx_tlast = 0;
  logic          rx_tuser = 0;
  logic          rx_alf;
  logic [DW-1:0] tx_tdata;
  logic          tx_tvalid;
  logic          tx_tlast;
  logic          tx_tuser;
  logic          tx_tready = 0;
  logic [CW-1:0] pkt_in_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] pkt_out_cnt;

  pkt_async_fifo_sf #(
    .DATA_W(DW), .ADDR_W(AW), .ALF_THRESH(ALF), .CNT_W(CW)
  ) dut (
    .wrclk       (wrclk),
    .wr_reset    (wr_reset),
    .rdclk       (rdclk),
    .rd_reset    (rd_reset),
    .rx_tdata    (rx_tdata),
    .rx_tvalid   (rx_tvalid),
    .rx_tlast    (rx_tlast),
    .rx_tuser    (rx_tuser),
    .rx_alf      (rx_alf),
    .tx_tdata    (tx_tdata),
    .tx_tvalid   (tx_tvalid),
    .tx_tlast    (tx_tlast),
    .tx_tuser    (tx_tuser),
    .tx_tready   (tx_tready),
    .pkt_in_cnt  (pkt_in_cnt),
    .drop_cnt    (drop_cnt),
    .pkt_out_cnt (pkt_out_cnt)
  );

  always #5 wrclk = ~wrclk;
  always #4 rdclk = ~rdclk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_in = 0;
  int    exp_drop = 0;
  int    exp_out = 0;
  int    tready_mode = 0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge rdclk);
    #1;
    case (tready_mode)
      1:       tx_tready = 1'b1;
      2:       tx_tready = 1'($urandom_range(0, 1));
      default: tx_tready = 1'b0;
    endcase
  end

  // per-cycle compare of the tx stream against the expected queue
  initial begin
    logic       prev_stall;
    beat_t      prev;
    beat_t      e;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge rdclk);
      if (!rd_reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(tx_tvalid), 64'd1);
          chk("hold_data", 64'({tx_tlast, tx_tdata}), 64'(prev));
        end
        if (tx_tvalid && tx_tready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h, nothing expected",
                     {tx_tlast, tx_tdata});
          end else begin
            e = exp_q.pop_front();
            chk("tx_beat", 64'({tx_tuser, tx_tlast, tx_tdata}),
                64'({1'b0, e}));
            if (e.last) begin
              exp_out++;
              last_data = tx_tdata;
            end
          end
        end
        prev_stall = tx_tvalid && !tx_tready;
        prev = {tx_tlast, tx_tdata};
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic beat(input logic [DW-1:0] d, input logic l,
                      input logic u, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) begin
      @(posedge wrclk);
      #1;
    end
    rx_tdata  = d;
    rx_tlast  = l;
    rx_tuser  = u;
    rx_tvalid = 1'b1;
    @(posedge wrclk);
    #1;
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
  endtask

  // model: a packet survives if error-free, started below the
  // almost-full level and fits in the space left at its start
  task automatic send_pkt(input int len, input bit err, input int seed,
                          input bit gaps);
    int held;
    bit ok;
    held = exp_q.size();
    ok = !err && held < ALF && held + len <= DEPTH;
    if (ok) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back({i == len - 1, DW'(seed + i)});
      exp_in++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < len; i++)
      beat(DW'(seed + i), i == len - 1, err && i == len - 1, gaps);
  endtask

  task automatic wait_drain(input int maxc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || tx_tvalid) && c < maxc) begin
      @(negedge rdclk);
      c++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (20) @(posedge wrclk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int ein,
                           input int edrop, input int eout);
    chk({tag, "_pkt_in"}, 64'(pkt_in_cnt), 64'(CW'(ein)));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(CW'(edrop)));
    chk({tag, "_pkt_out"}, 64'(pkt_out_cnt), 64'(CW'(eout)));
  endtask

  initial begin
    #33;
    chk("rst_tvalid", 64'(tx_tvalid), 64'd0);
    chk("rst_alf", 64'(rx_alf), 64'd0);
    check_cnt("rst", 0, 0, 0);
    #14;
    wr_reset = 1;
    rd_reset = 1;
    @(posedge wrclk);
    #1;

    send_pkt(64, 0, 0, 0);
    repeat (10) @(negedge rdclk);
    chk("t1_fwft_valid", 64'(tx_tvalid), 64'd1);
    chk("t1_fwft_data", 64'(tx_tdata), 64'h00);
    tready_mode = 1;
    wait_drain(500);
    chk("t1_last_data", 64'(last_data), 64'h3F);
    check_cnt("t1", 1, 0, 1);

    send_pkt(60, 1, 'h40, 0);
    send_pkt(60, 0, 'h80, 0);
    wait_drain(500);
    chk("t2_last_data", 64'(last_data), 64'hBB);
    check_cnt("t2", 2, 1, 2);

    tready_mode = 0;
    repeat (3) @(posedge wrclk);
    #1;
    for (int p = 0; p < 20; p++)
      send_pkt(64, 0, p * 16, 0);
    repeat (5) @(posedge wrclk);
    #1;
    chk("t3_alf", 64'(rx_alf), 64'd1);
    chk("t3_model_held", 64'(exp_q.size()), 64'd768);
    check_cnt("t3_fill", 14, 9, 2);
    tready_mode = 1;
    wait_drain(3000);
    chk("t3_alf_clear", 64'(rx_alf), 64'd0);
    check_cnt("t3", 14, 9, 14);

    send_pkt(1100, 0, 'h11, 0);
    send_pkt(64, 0, 'h22, 0);
    wait_drain(1000);
    chk("t4_last_data", 64'(last_data), 64'h61);
    check_cnt("t4", 15, 10, 15);
    chk("t4_model_drop", 64'(exp_drop), 64'd10);

    tready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int c;
      c = 0;
      while (exp_q.size() >= 300 && c < 5000) begin
        @(posedge wrclk);
        c++;
      end
      if (c >= 5000)
        chk("t5_backlog", 64'(exp_q.size()), 64'd0);
      #1;
      send_pkt($urandom_range(1, 255), $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 255)), 1);
    end
    wait_drain(20000);
    check_cnt("t5", exp_in, exp_drop, exp_out);

    tready_mode = 0;
    send_pkt(20, 0, 'h33, 0);
    for (int i = 0; i < 10; i++)
      beat(DW'('hA0 + i), 0, 0, 0);
    wr_reset = 0;
    rd_reset = 0;
    exp_q.delete();
    exp_in = 0;
    exp_drop = 0;
    exp_out = 0;
    repeat (3) @(posedge wrclk);
    #1;
    chk("t6_tvalid", 64'(tx_tvalid), 64'd0);
    chk("t6_tdata", 64'(tx_tdata), 64'd0);
    chk("t6_tlast", 64'(tx_tlast), 64'd0);
    chk("t6_alf", 64'(rx_alf), 64'd0);
    check_cnt("t6_rst", 0, 0, 0);
    wr_reset = 1;
    rd_reset = 1;
    @(posedge wrclk);
    #1;
    tready_mode = 1;
    send_pkt(30, 0, 'h55, 0);
    wait_drain(500);
    chk("t6_last_data", 64'(last_data), 64'h72);
    check_cnt("t6", 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
